// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status-flag control for a power-of-two
// FIFO whose storage array lives outside this block. Zero fall-through: a
// write lands in storage at the clk edge and is never seen on readAddr in
// its own write cycle.
module fifo_ctrl #(
    parameter int eC      = 8,
    parameter int aW      = $clog2(eC),
    parameter int afLevel = eC - 2,
    parameter int aeLevel = 2
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          push,
    input  logic          pop,
    output logic          writeEn,
    output logic [aW-1:0] writeAddr,
    output logic [aW-1:0] readAddr,
    output logic          full,
    output logic          empty,
    output logic          almostFull,
    output logic          almostEmpty,
    output logic [aW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [aW:0] CNT_MAX = (aW + 1)'(eC);
    localparam logic [aW:0] AF_LVL  = (aW + 1)'(afLevel);
    localparam logic [aW:0] AE_LVL  = (aW + 1)'(aeLevel);
    localparam logic [aW:0] ONE     = (aW + 1)'(1);

    // Pointers carry one extra wrap bit above the storage address.
    logic [aW:0] wrPtr;
    logic [aW:0] rdPtr;
    logic [aW:0] cntNext;
    logic        wrAcc;
    logic        rdAcc;

    // Request acceptance against the flags registered at the start of the
    // cycle, and the occupancy those accepted requests will produce.
    always_comb begin
        wrAcc   = push && !full;
        rdAcc   = pop && !empty;
        cntNext = count;
        case ({wrAcc, rdAcc})
            2'b10:   cntNext = count + ONE;
            2'b01:   cntNext = count - ONE;
            default: cntNext = count;
        endcase
    end

    // The write strobe is held off during reset so no storage write slips
    // through while control state is being cleared.
    assign writeEn   = wrAcc && rstN;
    assign writeAddr = wrPtr[aW-1:0];
    assign readAddr  = rdPtr[aW-1:0];

    // Control state update; flags are registered from the next occupancy so
    // they always agree with count in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almostFull  <= 1'b0;
            almostEmpty <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + ONE;
            if (rdAcc) rdPtr <= rdPtr + ONE;
            count       <= cntNext;
            full        <= (cntNext == CNT_MAX);
            empty       <= (cntNext == '0);
            almostFull  <= (cntNext >= AF_LVL);
            almostEmpty <= (cntNext <= AE_LVL);
            overflow    <= push && full;
            underflow   <= pop && empty;
        end
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001: Parameter eC, default 8, SHALL set the number of FIFO entries; it SHALL be a power of two, at least 2.
REQ-002: Parameter aW, default $clog2(eC), SHALL set the address width driven to the storage array.
REQ-003: Parameter afLevel, default eC-2, SHALL set the almost-full threshold (entries).
REQ-004: Parameter aeLevel, default 2, SHALL set the almost-empty threshold (entries).
REQ-005: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006: rstN  in  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-007: push  in  1  write request; data is presented to storage by the producer in the same cycle.
REQ-008: pop  in  1  read request; consumes the entry at readAddr.
REQ-009: writeEn  out  1  storage write strobe.
REQ-010: writeAddr  out  aW  storage write address.
REQ-011: readAddr  out  aW  storage read address; storage read data is combinational from this address.
REQ-012: full, empty, almostFull, almostEmpty  out  1 each  status flags.
REQ-013: count  out  aW+1  current occupancy, 0..eC.
REQ-014: overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-015: Write and read pointers SHALL each be aW+1 bits; writeAddr/readAddr SHALL be their low aW bits, and the MSB SHALL be the wrap bit.
REQ-016: Push accepted = push && !full; pop accepted = pop && !empty; full/empty SHALL be the registered values from the start of the cycle.
REQ-017: writeEn SHALL be combinational and equal to push accepted; no other path SHALL assert it.
REQ-018: An accepted push SHALL increment the write pointer by 1 at the clk edge; an accepted pop SHALL increment the read pointer by 1.
REQ-019: Pointers SHALL wrap modulo 2*eC with no skipped or stalled state; the address wraps from eC-1 to 0.
REQ-020: count SHALL change as follows: push only +1; pop only -1; both or neither, unchanged.
REQ-021: Push and pop both accepted in one cycle (0<count<eC) SHALL leave count and all flags unchanged while both pointers advance.
REQ-022: When full, simultaneous push and pop SHALL accept the pop only, reject the push, and drop count to eC-1.
REQ-023: When empty, simultaneous push and pop SHALL accept the push only and reject the pop; count SHALL become 1.
REQ-024: Data read from storage at readAddr SHALL be valid whenever empty=0; a write is never visible to readAddr in its own write cycle (zero fall-through).
REQ-025: full SHALL be registered and equal (count==eC).
REQ-026: empty SHALL be registered and equal (count==0).
REQ-027: almostFull SHALL be registered and equal (count>=afLevel).
REQ-028: almostEmpty SHALL be registered and equal (count<=aeLevel).
REQ-029: overflow SHALL pulse high for exactly one cycle, in the cycle after push was sampled while full=1.
REQ-030: underflow SHALL pulse high for exactly one cycle, in the cycle after pop was sampled while empty=1.
REQ-031: A rejected request SHALL leave pointers, count and all flags unchanged.

Reset
REQ-032: While rstN=0 at a clk edge, the following SHALL apply on that edge regardless of push/pop:
- both pointers and count SHALL reset to 0;
- empty=1 and almostEmpty=1;
- full=0 and almostFull=0 (afLevel>0);
- overflow=0 and underflow=0.
REQ-033: writeEn SHALL be forced to 0 while rstN=0.
REQ-034: Reset asserted mid-operation SHALL discard all contents; the first pop after reset SHALL be rejected.
REQ-035: Storage contents SHALL NOT be cleared; only control state is reset.

Verification (eC=8, afLevel=6, aeLevel=2)
REQ-036: Reset, then push 8 back-to-back -> writeAddr steps 0..7; full=1 and count=8 after the 8th edge; almostFull=1 after the 6th.
REQ-037: From full, push=1 one cycle -> writeEn=0, count stays 8, overflow=1 for exactly one cycle.
REQ-038: From full, push=1 and pop=1 together -> count=7, full=0, readAddr advances, writeAddr unchanged.
REQ-039: From empty, pop=1 -> underflow pulse, readAddr stays; then push=1 and pop=1 together -> count=1, empty=0.
REQ-040: Wrap test: 20 push/pop pairs at count=3 -> addresses wrap 7->0, count stays 3, flags stable.
REQ-041: rstN=0 for one cycle at count=5 -> next cycle count=0, empty=1, both addresses 0, writeEn=0 during reset.
